// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_t;

    // Wide enough to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instr} entries with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; consumers only look at head while count != 0.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers responses for decode.
module fetch_unit #(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int              FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pcplus4,
    output logic            misalign_err
);

    import fetch_pkg::*;

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam int FW = 32 + XLEN;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_flight;
    logic [FW-1:0]   fifo_head;
    logic            req_fire;
    logic            push;
    logic            pop;

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit: live requests plus buffered entries never exceed the buffer, so pushes always fit.
    assign in_flight      = {1'b0, outstanding} - {1'b0, drop_cnt} + {1'b0, fifo_count};
    assign imem_req_valid = (state != BOOT) && !redirect_valid
                            && (in_flight < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_valid = (fifo_count != '0);
    assign pop       = dec_valid && dec_ready;
    assign push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    assign dec_instr   = dec_valid ? fifo_head[31:0] : '0;
    assign dec_pc      = dec_valid ? fifo_head[FW-1:32] : '0;
    assign dec_pcplus4 = dec_valid ? fifo_head[FW-1:32] + XLEN'(4) : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        if (redirect_valid) begin
            drop_next  = outstanding - CW'(imem_rsp_valid);
            state_next = (drop_next != '0) ? FLUSH : RUN;
        end else begin
            if (imem_rsp_valid && drop_cnt != '0) drop_next = drop_cnt - 1'b1;
            case (state)
                BOOT:    state_next = RUN;
                RUN:     state_next = RUN;
                FLUSH:   if (drop_next == '0) state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= BOOT;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc     <= RESET_PC;
            rsp_pc       <= RESET_PC;
            outstanding  <= '0;
            drop_cnt     <= '0;
            misalign_err <= 1'b0;
        end else begin
            drop_cnt     <= drop_next;
            outstanding  <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
            end
        end
    end

    // A redirect flushes the buffer, overriding any same-cycle push or pop.
    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable in-order memory responder.
module tb_fetch_unit;

    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus4;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit tag_data = 1'b0;
    int mcyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] got_pc[$];

    // Expected trace for the first eight cycles after reset release (latency 1, decode ready).
    localparam logic [7:0] EXP_RV = 8'b1101_1011;
    localparam logic [7:0] EXP_DV = 8'b0110_1100;
    logic [31:0] exp_ra [8] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h10, 32'h10, 32'h14};
    logic [31:0] exp_dp [8] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0};

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pcplus4    (dec_pcplus4),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return tag_data ? {a[24:0], 7'h13} : NOP_INSTR;
    endfunction

    // In-order memory: a request accepted at edge c is returned right after edge c+lat-1.
    always @(posedge clk) begin
        mcyc++;
        if (!reset_n) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, mcyc + lat - 1});
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
                imem_rsp_data  <= '0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset_n)                     got_pc.delete();
        else if (dec_valid && dec_ready)  got_pc.push_back(dec_pc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_req_addr"},  imem_req_addr, RESET_PC);
        check({tag, "_dec_valid"}, dec_valid, 0);
        check({tag, "_dec_instr"}, dec_instr, 0);
        check({tag, "_dec_pc"},    dec_pc, 0);
        check({tag, "_dec_pc4"},   dec_pcplus4, 0);
        check({tag, "_misalign"},  misalign_err, 0);
        check({tag, "_state"},     dut.state, BOOT);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (got_pc.size() > i) ? got_pc[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = 1;
        tag_data       = 1'b0;

        // Reset values, then the BOOT cycle issues nothing.
        repeat (2) tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        #1;
        check("boot_no_req", imem_req_valid, 0);

        // Streaming with 1-cycle memory: first instruction reaches decode 3 cycles after release.
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("run%0d_rv", i), imem_req_valid, EXP_RV[i]);
            check($sformatf("run%0d_ra", i), imem_req_addr, exp_ra[i]);
            check($sformatf("run%0d_dv", i), dec_valid, EXP_DV[i]);
            check($sformatf("run%0d_dp", i), dec_pc, exp_dp[i]);
            check($sformatf("run%0d_di", i), dec_instr, EXP_DV[i] ? NOP_INSTR : 32'h0);
            check($sformatf("run%0d_p4", i), dec_pcplus4, EXP_DV[i] ? exp_dp[i] + 32'd4 : 32'h0);
        end

        // Decode stall: buffer fills, requests stop, head holds.
        dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stall%0d_dv", i), dec_valid, 1);
            check($sformatf("stall%0d_dp", i), dec_pc, 32'h10);
            check($sformatf("stall%0d_di", i), dec_instr, NOP_INSTR);
            check($sformatf("stall%0d_rv", i), imem_req_valid, 0);
        end
        dec_ready = 1'b1;
        tick();
        check("unstall_dp", dec_pc, 32'h14);
        check("unstall_rv", imem_req_valid, 1);
        check("unstall_ra", imem_req_addr, 32'h18);
        tick();
        check("unstall2_dv", dec_valid, 0);
        check("unstall2_ra", imem_req_addr, 32'h1C);
        repeat (10) tick();
        begin
            int bad = 0;
            foreach (got_pc[i]) if (got_pc[i] !== 32'(i * 4)) bad++;
            check("seq_order", bad, 0);
            check("seq_len", got_pc.size(), 12);
        end

        // Redirect with two requests outstanding at latency 3.
        tag_data = 1'b1;
        lat      = 3;
        do_reset();
        repeat (3) tick();
        check("r1_two_out_rv", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("r1_redirect_blocks_req", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("r1_state_flush", dut.state, FLUSH);
        check("r1_drop_cnt", dut.drop_cnt, 2);
        check("r1_rv", imem_req_valid, 1);
        check("r1_ra", imem_req_addr, 32'h100);
        check("r1_misalign", misalign_err, 0);
        tick();
        check("r1_e5_ra", imem_req_addr, 32'h104);
        check("r1_e5_dv", dec_valid, 0);
        check("r1_e5_state", dut.state, FLUSH);
        tick();
        check("r1_e6_state", dut.state, RUN);
        check("r1_e6_dv", dec_valid, 0);
        tick();
        check("r1_e7_dv", dec_valid, 0);
        tick();
        check("r1_e8_dv", dec_valid, 1);
        check("r1_e8_dp", dec_pc, 32'h100);
        check("r1_e8_p4", dec_pcplus4, 32'h104);
        check("r1_e8_di", dec_instr, 32'h0000_8013);
        tick();
        check("r1_e9_dp", dec_pc, 32'h104);
        check("r1_e9_di", dec_instr, 32'h0000_8213);
        check("r1_got_n", got_pc.size(), 1);
        check("r1_got0", got_at(0), 32'h100);

        // Misaligned redirect target.
        lat = 1;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        check("mis_rv", imem_req_valid, 0);
        check("mis_pre", misalign_err, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("mis_pulse", misalign_err, 1);
        check("mis_ra", imem_req_addr, 32'h100);
        tick();
        check("mis_clear", misalign_err, 0);
        tick();
        check("mis_dp", dec_pc, 32'h100);
        check("mis_di", dec_instr, 32'h0000_8013);

        // Redirect coinciding with a response and a decode handshake.
        do_reset();
        repeat (3) tick();
        check("co_dv", dec_valid, 1);
        check("co_dp", dec_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check("co_rv", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("co_got_n", got_pc.size(), 1);
        check("co_got0", got_at(0), 32'h0);
        check("co_dv_after", dec_valid, 0);
        check("co_drop", dut.drop_cnt, 0);
        check("co_out", dut.outstanding, 0);
        check("co_state", dut.state, RUN);
        check("co_ra", imem_req_addr, 32'h200);
        tick();
        check("co_e5_dv", dec_valid, 0);
        tick();
        check("co_e6_dp", dec_pc, 32'h200);
        check("co_e6_di", dec_instr, 32'h0001_0013);
        tick();
        check("co_got_n2", got_pc.size(), 2);
        check("co_got1", got_at(1), 32'h200);

        // Reset in the middle of a flush with responses still pending.
        lat = 3;
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("mf_state", dut.state, FLUSH);
        reset_n = 1'b0;
        lat     = 1;
        repeat (2) tick();
        check_reset_outputs("mf_rst");
        reset_n = 1'b1;
        #1;
        repeat (3) tick();
        check("mf_dv", dec_valid, 1);
        check("mf_dp", dec_pc, RESET_PC);
        check("mf_di", dec_instr, 32'h0000_0013);
        tick();
        check("mf_got0", got_at(0), RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/control stage.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake; decode's main decoder consumes dec_instr[6:0] as its opcode.
- Accepts redirects (taken branch, jal, jalr) from execute, flushes stale work, and restarts at the target.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response data valid (in order, >=1 cycle after acceptance)
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  execute redirect pulse
redirect_pc  in  XLEN  redirect target (PCTarget or ALUResult per PCResultSrc)
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode accepts (low = stall)
dec_instr  out  32  instruction at FIFO head
dec_pc  out  XLEN  PC of dec_instr
dec_pcplus4  out  XLEN  dec_pc + 4
misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (reset_n=0 at clk edge):
  - fetch_pc = rsp_pc = RESET_PC; outstanding = drop_cnt = 0; FIFO empty; state = BOOT.
  - All outputs 0, except imem_req_addr = RESET_PC.
- FSM:
  - BOOT: one cycle, no request, then RUN.
  - RUN: normal operation.
  - FLUSH: drop_cnt > 0. New requests are still permitted; return to RUN when drop_cnt reaches 0.
  - Reset in any state returns to BOOT.
- Request issue:
  - imem_req_valid = (state != BOOT) & !redirect_valid & (outstanding − drop_cnt + fifo_count < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On acceptance: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding++.
- Response:
  - Arriving response decrements outstanding.
  - If drop_cnt > 0: discard it, drop_cnt--.
  - Else: push {rsp_pc, imem_rsp_data}, rsp_pc += 4.
  - Credit rule guarantees no push into a full FIFO; a push when full is an assertion failure.
- Decode side:
  - dec_valid = FIFO non-empty; dec_* driven from FIFO head registers.
  - Pop when dec_valid & dec_ready.
  - Latency: response to dec_valid is 1 cycle. Request acceptance to dec_valid is at least 2 cycles.
  - Outputs hold stable while dec_valid & !dec_ready.
- Redirect (redirect_valid=1):
  - target = {redirect_pc[XLEN-1:2], 2'b00}; misalign_err = |redirect_pc[1:0] on the next cycle for one cycle.
  - fetch_pc = rsp_pc = target; FIFO flushed, including any pop or push in the same cycle.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0).
  - No request is issued in the redirect cycle.
  - Next state = FLUSH if the new drop_cnt > 0, else RUN.
- Simultaneous events:
  - Redirect with a decode handshake: the handshake completes (decode takes the instruction), and the FIFO is still flushed.
  - Redirect during FLUSH: recompute drop_cnt from outstanding as above.
  - Push and pop in the same cycle with FIFO full: not possible, since the push is pre-reserved by credit.
- No combinational path from dec_ready or imem_rsp_* to imem_req_valid. redirect_valid → imem_req_valid is the only combinational input-to-output path.

Decomposition:
- fetch_pkg holds:
  - XLEN
  - RESET_PC
  - NOP_INSTR = 32'h0000_0013
  - state enum {BOOT, RUN, FLUSH}
  - outstanding/drop counter width = $clog2(FIFO_DEPTH)+1
- Sub-module fetch_fifo:
  - Synchronous FIFO, width 32+XLEN, depth FIFO_DEPTH.
  - Ports: push/pop/flush, exposes count/head.
  - Resets empty under the same reset_n.

Test Plan:
- Reset then memory with ready=1 and 1-cycle latency returning 0x00000013 for all addresses, dec_ready=1 → requests at 0x0,0x4,0x8…; first dec_valid 3 cycles after reset release with dec_pc=0x0, dec_pcplus4=0x4.
- dec_ready=0 for 10 cycles → at most FIFO_DEPTH outstanding+buffered; imem_req_valid drops; dec_instr/dec_pc stable; on release, PCs continue 0x0,0x4 with no gaps or duplicates.
- Two requests outstanding (latency 3), redirect_pc=0x100 → both stale responses discarded, state FLUSH then RUN; next dec_pc=0x100; no stale instruction reaches decode.
- redirect_pc=0x102 → fetch from 0x100, misalign_err pulses exactly one cycle.
- Redirect in the same cycle as imem_rsp_valid and a dec handshake → the handshake instruction is consumed once, the response is dropped, drop_cnt = outstanding−1, and the next dec_pc equals the target.
- reset_n asserted low mid-FLUSH with responses pending → all outputs 0, restart at RESET_PC, no pre-reset response is delivered to decode (memory also reset by the bench).
